// File: rtl/align_reg_out.sv
// Output deskew stage for the systolic conv array: delays lane k by (LANE_NUM-1-k)
// cycles so a skewed result vector leaves aligned, with regenerated valid/last framing.
module align_reg_out #(
    parameter int LANE_NUM   = 9,
    parameter int GROUP_NUM  = 18,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_REG    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clear,
    input  logic                                     valid_in,
    input  logic                                     last_in,
    input  logic [DATA_WIDTH*LANE_NUM*GROUP_NUM-1:0] data_in,
    output logic                                     valid_out,
    output logic                                     last_out,
    output logic [DATA_WIDTH*LANE_NUM*GROUP_NUM-1:0] data_out,
    output logic [CNT_WIDTH-1:0]                     vec_cnt,
    output logic                                     busy
);

    localparam int SKEW       = LANE_NUM - 1;
    localparam int FLAG_DEPTH = SKEW + OUT_REG;
    localparam int BUS_W      = DATA_WIDTH * LANE_NUM * GROUP_NUM;

    logic [BUS_W-1:0]     aligned_s;
    logic                 cnt_inc_s;
    logic [CNT_WIDTH-1:0] vec_cnt_d;
    logic [CNT_WIDTH-1:0] vec_cnt_q;

    genvar g, k;
    generate
        for (g = 0; g < GROUP_NUM; g++) begin : g_group
            for (k = 0; k < LANE_NUM; k++) begin : g_lane
                localparam int DEPTH = SKEW - k;
                localparam int LSB   = (g * LANE_NUM + k) * DATA_WIDTH;
                if (DEPTH == 0) begin : g_pass
                    // The last lane to arrive is already aligned with the others.
                    assign aligned_s[LSB +: DATA_WIDTH] = data_in[LSB +: DATA_WIDTH];
                end else begin : g_chain
                    logic [DEPTH-1:0][DATA_WIDTH-1:0] chain_d;
                    logic [DEPTH-1:0][DATA_WIDTH-1:0] chain_q;

                    // Next state of this lane's private delay line.
                    always_comb begin
                        chain_d = '0;
                        if (!clear) begin
                            chain_d[0] = data_in[LSB +: DATA_WIDTH];
                            for (int i = 1; i < DEPTH; i++) begin
                                chain_d[i] = chain_q[i-1];
                            end
                        end else begin
                            chain_d = '0;
                        end
                    end

                    // Delay line register.
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            chain_q <= '0;
                        end else begin
                            chain_q <= chain_d;
                        end
                    end

                    assign aligned_s[LSB +: DATA_WIDTH] = chain_q[DEPTH-1];
                end
            end
        end

        if (FLAG_DEPTH == 0) begin : g_no_flags
            assign valid_out = valid_in & ~clear;
            assign last_out  = valid_in & last_in & ~clear;
            assign busy      = 1'b0;
            assign cnt_inc_s = valid_out;
        end else begin : g_flags
            logic [FLAG_DEPTH-1:0] vld_d;
            logic [FLAG_DEPTH-1:0] vld_q;
            logic [FLAG_DEPTH-1:0] lst_d;
            logic [FLAG_DEPTH-1:0] lst_q;

            // Framing pipeline; clear also swallows a valid_in on the same cycle.
            always_comb begin
                vld_d = '0;
                lst_d = '0;
                if (!clear) begin
                    vld_d[0] = valid_in;
                    lst_d[0] = valid_in & last_in;
                    for (int i = 1; i < FLAG_DEPTH; i++) begin
                        vld_d[i] = vld_q[i-1];
                        lst_d[i] = lst_q[i-1];
                    end
                end else begin
                    vld_d = '0;
                    lst_d = '0;
                end
            end

            // Framing pipeline register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= '0;
                    lst_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    lst_q <= lst_d;
                end
            end

            assign valid_out = vld_q[FLAG_DEPTH-1];
            assign last_out  = lst_q[FLAG_DEPTH-1];
            assign busy      = |vld_q;
            // Counting the value about to be loaded keeps vec_cnt in step with valid_out.
            assign cnt_inc_s = vld_d[FLAG_DEPTH-1];
        end

        if (OUT_REG != 0) begin : g_out_reg
            logic [BUS_W-1:0] data_out_d;
            logic [BUS_W-1:0] data_out_q;

            // Output data register input.
            always_comb begin
                data_out_d = '0;
                if (clear) begin
                    data_out_d = '0;
                end else begin
                    data_out_d = aligned_s;
                end
            end

            // Output data register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out_q <= '0;
                end else begin
                    data_out_q <= data_out_d;
                end
            end

            assign data_out = data_out_q;
        end else begin : g_out_comb
            assign data_out = aligned_s;
        end
    endgenerate

    // Aligned-vector counter next state; wraps naturally at 2^CNT_WIDTH.
    always_comb begin
        vec_cnt_d = vec_cnt_q;
        if (clear) begin
            vec_cnt_d = '0;
        end else if (cnt_inc_s) begin
            vec_cnt_d = vec_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            vec_cnt_d = vec_cnt_q;
        end
    end

    // Aligned-vector counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt_q <= '0;
        end else begin
            vec_cnt_q <= vec_cnt_d;
        end
    end

    assign vec_cnt = vec_cnt_q;

endmodule
